// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared single-port program/data memory.
// One transaction in flight; read data is routed back to the port that issued it.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic               last;
  logic               owner;
  logic [CNT_W-1:0]   cnt;
  logic               pick1;

  // Port 1 wins if it is the only requester, or on a tie when port 0 was served last.
  assign pick1 = req1 & (~req0 | ~last);

  // State, latched transaction and all outputs; the mem_* registers double as the latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      cnt       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= pick1;
            last      <= pick1;
            mem_en    <= 1'b1;
            mem_we    <= pick1 ? we1 : we0;
            mem_addr  <= pick1 ? addr1 : addr0;
            mem_wdata <= pick1 ? wdata1 : wdata0;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (RD_LAT == 1) begin
            state <= RESP;
          end else begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (owner) begin
            rdata1  <= mem_rdata;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_rdata;
            rvalid0 <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with RD_LAT=1 (index 0), one with RD_LAT=3 (index 1),
// each backed by its own behavioural memory.
module tb_mem_port_arbiter;

  typedef struct {
    bit          owner;
    bit          we;
    logic [7:0]  addr;
    logic [23:0] wdata;
  } acc_t;

  logic        clk;
  logic        reset;
  logic        req0 [2];
  logic        we0 [2];
  logic [7:0]  addr0 [2];
  logic [23:0] wdata0 [2];
  logic        gnt0 [2];
  logic        rvalid0 [2];
  logic [23:0] rdata0 [2];
  logic        req1 [2];
  logic        we1 [2];
  logic [7:0]  addr1 [2];
  logic [23:0] wdata1 [2];
  logic        gnt1 [2];
  logic        rvalid1 [2];
  logic [23:0] rdata1 [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [7:0]  mem_addr [2];
  logic [23:0] mem_wdata [2];
  logic [23:0] mem_rdata [2];
  logic        busy [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  acc_t        acc_q[$];
  logic [23:0] rd_q[$];

  logic [23:0] mem_a [2][256];
  logic [23:0] pipe1;
  logic [23:0] pipe3 [3];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(24), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .gnt0(gnt0[0]), .rvalid0(rvalid0[0]), .rdata0(rdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .gnt1(gnt1[0]), .rvalid1(rvalid1[0]), .rdata1(rdata1[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(24), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .gnt0(gnt0[1]), .rvalid0(rvalid0[1]), .rdata0(rdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .gnt1(gnt1[1]), .rvalid1(rvalid1[1]), .rdata1(rdata1[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories; unread cycles present a marker value so a mistimed capture shows up.
  always @(posedge clk) begin
    if (mem_en[0] && mem_we[0]) mem_a[0][mem_addr[0]] <= mem_wdata[0];
    if (mem_en[1] && mem_we[1]) mem_a[1][mem_addr[1]] <= mem_wdata[1];
    pipe1    <= (mem_en[0] && !mem_we[0]) ? mem_a[0][mem_addr[0]] : 24'hBADBAD;
    pipe3[0] <= (mem_en[1] && !mem_we[1]) ? mem_a[1][mem_addr[1]] : 24'hBADBAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign mem_rdata[0] = pipe1;
  assign mem_rdata[1] = pipe3[2];

  // Raise one request and wait (bounded) for its grant; returns the grant cycle or -1.
  task automatic issue(input int k, input bit port, input bit we, input logic [7:0] a,
                       input logic [23:0] d, output int gcyc);
    gcyc = -1;
    if (port) begin
      req1[k] = 1'b1; we1[k] = we; addr1[k] = a; wdata1[k] = d;
    end else begin
      req0[k] = 1'b1; we0[k] = we; addr0[k] = a; wdata0[k] = d;
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if ((port ? gnt1[k] : gnt0[k]) === 1'b1) begin
        gcyc = cyc;
        break;
      end
    end
    req0[k] = 1'b0;
    req1[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], rdata0[k], rdata1[k], mem_en[k], mem_we[k],
           mem_addr[k], mem_wdata[k], busy[k]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d got en=%b we=%b addr=%h wdata=%h busy=%b gnt=%b%b rv=%b%b rd0=%h rd1=%h want all 0",
                 k, mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], busy[k], gnt0[k], gnt1[k],
                 rvalid0[k], rvalid1[k], rdata0[k], rdata1[k]);
      end
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | mem_en[0] | mem_en[1] | busy[0] | busy[1];
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet got activity=%b want 0", seen);
    end
  endtask

  task automatic test_write(input int k);
    int g;
    acc_t e;
    acc_q.push_back('{owner: 1'b0, we: 1'b1, addr: 8'h05, wdata: 24'hABCDEF});
    issue(k, 1'b0, 1'b1, 8'h05, 24'hABCDEF, g);
    e = acc_q.pop_front();
    total++;
    if (g < 0) begin
      bad++;
      $display("FAIL write_gnt0 inst=%0d got no grant want gnt0 within bound", k);
    end
    total++;
    if ({gnt1[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k]} !== {1'b0, 1'b1, e.we, e.addr, e.wdata}) begin
      bad++;
      $display("FAIL write_access inst=%0d got gnt1=%b en=%b we=%b addr=%h wdata=%h want 0 1 %b %h %h",
               k, gnt1[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], e.we, e.addr, e.wdata);
    end
    @(posedge clk); #1;
    total++;
    if ({gnt0[k], mem_en[k]} !== 2'b00) begin
      bad++;
      $display("FAIL write_pulse inst=%0d got gnt0=%b en=%b want 0 0", k, gnt0[k], mem_en[k]);
    end
    idle(2);
  endtask

  task automatic test_read(input int k);
    int g, g_wr, rv, pulses, saw0, lat;
    logic [23:0] got, want;
    lat = (k == 0) ? 1 : 3;
    issue(k, 1'b0, 1'b1, 8'h05, 24'h123456, g_wr);
    idle(1);
    rd_q.push_back(24'h123456);
    issue(k, 1'b1, 1'b0, 8'h05, 24'h0, g);
    total++;
    if (g < 0 || g_wr < 0) begin
      bad++;
      $display("FAIL read_gnt1 inst=%0d got write_g=%0d read_g=%0d want both granted", k, g_wr, g);
    end
    total++;
    if ({mem_en[k], mem_we[k], mem_addr[k]} !== {1'b1, 1'b0, 8'h05}) begin
      bad++;
      $display("FAIL read_access inst=%0d got en=%b we=%b addr=%h want 1 0 05",
               k, mem_en[k], mem_we[k], mem_addr[k]);
    end
    rv = -1; pulses = 0; saw0 = 0; got = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rvalid0[k] === 1'b1) saw0++;
      if (rvalid1[k] === 1'b1) begin
        pulses++;
        if (rv < 0) begin
          rv = cyc;
          got = rdata1[k];
        end
      end
    end
    want = rd_q.pop_front();
    total++;
    if (rv - g != lat + 1) begin
      bad++;
      $display("FAIL read_latency inst=%0d got %0d cycles want %0d", k, rv - g, lat + 1);
    end
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL read_data inst=%0d got %h want %h", k, got, want);
    end
    total++;
    if (pulses != 1 || saw0 != 0) begin
      bad++;
      $display("FAIL read_pulses inst=%0d got rvalid1 x%0d rvalid0 x%0d want 1 and 0", k, pulses, saw0);
    end
  endtask

  task automatic test_contention(input int k);
    int n;
    acc_t e;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) acc_q.push_back('{owner: 1'b0, we: 1'b1, addr: 8'h10, wdata: 24'h0A0A0A});
      else            acc_q.push_back('{owner: 1'b1, we: 1'b1, addr: 8'h20, wdata: 24'h1B1B1B});
    end
    req0[k] = 1'b1; we0[k] = 1'b1; addr0[k] = 8'h10; wdata0[k] = 24'h0A0A0A;
    req1[k] = 1'b1; we1[k] = 1'b1; addr1[k] = 8'h20; wdata1[k] = 24'h1B1B1B;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(posedge clk); #1;
      if (gnt0[k] === 1'b1 || gnt1[k] === 1'b1) begin
        e = acc_q.pop_front();
        total++;
        if ({gnt1[k], gnt0[k], mem_en[k], mem_addr[k], mem_wdata[k]} !== {e.owner, !e.owner, 1'b1, e.addr, e.wdata}) begin
          bad++;
          $display("FAIL contention_grant%0d inst=%0d got gnt1=%b gnt0=%b en=%b addr=%h wdata=%h want owner %0d addr %h wdata %h",
                   n, k, gnt1[k], gnt0[k], mem_en[k], mem_addr[k], mem_wdata[k], e.owner, e.addr, e.wdata);
        end
        n++;
      end
    end
    req0[k] = 1'b0;
    req1[k] = 1'b0;
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL contention_count inst=%0d got %0d grants want 4", k, n);
      acc_q.delete();
    end
    idle(3);
  endtask

  task automatic test_withdraw();
    int g, g_wr, gnt1_n, en_n, rv_n;
    logic [23:0] got, want;
    issue(1, 1'b0, 1'b1, 8'h33, 24'h777777, g_wr);
    idle(1);
    rd_q.push_back(24'h777777);
    issue(1, 1'b0, 1'b0, 8'h33, 24'h0, g);
    total++;
    if (g < 0 || g_wr < 0) begin
      bad++;
      $display("FAIL withdraw_setup got write_g=%0d read_g=%0d want both granted", g_wr, g);
    end
    @(posedge clk); #1;
    req1[1] = 1'b1; we1[1] = 1'b0; addr1[1] = 8'h44; wdata1[1] = 24'h0;
    @(posedge clk); #1;
    req1[1] = 1'b0;
    gnt1_n = 0; en_n = 0; rv_n = 0; got = '0;
    for (int i = 0; i < 10; i++) begin
      if (gnt1[1] === 1'b1) gnt1_n++;
      if (mem_en[1] === 1'b1) en_n++;
      if (rvalid0[1] === 1'b1) begin
        rv_n++;
        got = rdata0[1];
      end
      @(posedge clk); #1;
    end
    want = rd_q.pop_front();
    total++;
    if (gnt1_n != 0 || en_n != 0) begin
      bad++;
      $display("FAIL withdraw_ignored got gnt1 x%0d mem_en x%0d want 0 and 0", gnt1_n, en_n);
    end
    total++;
    if (rv_n != 1 || got !== want) begin
      bad++;
      $display("FAIL withdraw_read got rvalid0 x%0d data %h want 1 and %h", rv_n, got, want);
    end
  endtask

  task automatic test_reset_mid_read();
    int g, rv_n, first;
    issue(1, 1'b0, 1'b0, 8'h33, 24'h0, g);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    total++;
    if ({g >= 0, mem_en[1], busy[1], gnt0[1]} !== 4'b1000) begin
      bad++;
      $display("FAIL midreset_async got granted=%b en=%b busy=%b gnt0=%b want 1 0 0 0",
               g >= 0, mem_en[1], busy[1], gnt0[1]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 8'h55; wdata0[1] = 24'h555555;
    req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 8'h66; wdata1[1] = 24'h666666;
    rv_n = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rvalid0[1] === 1'b1 || rvalid1[1] === 1'b1) rv_n++;
      if (first < 0 && gnt0[1] === 1'b1) first = 0;
      else if (first < 0 && gnt1[1] === 1'b1) first = 1;
    end
    req0[1] = 1'b0;
    req1[1] = 1'b0;
    total++;
    if (rv_n != 0) begin
      bad++;
      $display("FAIL midreset_no_rvalid got rvalid x%0d want 0", rv_n);
    end
    total++;
    if (first != 0) begin
      bad++;
      $display("FAIL midreset_first_grant got port %0d want port 0", first);
    end
    idle(3);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0; we0[k] = 1'b0; addr0[k] = '0; wdata0[k] = '0;
      req1[k] = 1'b0; we1[k] = 1'b0; addr1[k] = '0; wdata1[k] = '0;
    end
    test_reset();
    test_write(0);
    test_write(1);
    test_read(0);
    test_read(1);
    test_contention(0);
    test_contention(1);
    test_withdraw();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
